cache_way_array: RTL

- Parametrised N-way set-associative cache storage: per-way data lines with byte write strobes, plus a tag array carrying valid and dirty bits.
- Single-cycle-issue, 1-cycle-latency lookup with tag compare, hit-way select and victim reporting.
- Round-robin victim pointer per set.
- Reset-time and on-demand valid/dirty clear is done by a sweep FSM, not a reset loop. Sits under the I/D cache controllers.

---
 rtl/cache_way_array_pkg.sv | 34 +++
 rtl/cache_way_bank.sv | 94 +++++++++
 rtl/cache_way_array.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cache_way_array_pkg.sv
// -----------------------------------------------------------------------------
// cache_way_array_pkg
// Shared types for the set-associative cache storage block:
//   req_op_e      request opcode (LOOKUP / WRITE / FILL / INVAL)
//   sweep_state_e valid/dirty clear sweep FSM state
//   tag_meta_t    per-entry flag bits; the tag itself is a module-parameter
//                 width, so it lives in a parallel array beside these flags
//                 (which also lets the sweep clear flags without touching tags)
// Optional feature macro: CACHE_ARRAY_PARITY_EN adds an even-parity bit over
// {tag, dirty} to each entry.
// -----------------------------------------------------------------------------
package cache_way_array_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_WRITE  = 2'd1,
        OP_FILL   = 2'd2,
        OP_INVAL  = 2'd3
    } req_op_e;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } sweep_state_e;

    typedef struct packed {
        logic dirty;
        logic valid;
`ifdef CACHE_ARRAY_PARITY_EN
        logic parity;
`endif
    } tag_meta_t;

endpackage

// File: rtl/cache_way_bank.sv
// -----------------------------------------------------------------------------
// cache_way_bank
// One way of the cache: line data array with byte strobes, tag array and
// per-entry valid/dirty flags. Reads are asynchronous on idx_i so a lookup the
// cycle after a write sees the new contents.
// Ports:
//   clk                 clock
//   clr_en_i/clr_idx_i  sweep clear of the flags at one set
//   wr_en_i/op_i        this way is the target of an accepted WRITE/FILL/INVAL
//   idx_i               set index for both the write and the read
//   tag_i/wdata_i/wstrb_i/dirty_i  write payload
//   rd_tag_o/rd_meta_o/rd_data_o   contents of set idx_i
// Optional feature macro: CACHE_ARRAY_PARITY_EN (maintains the parity bit).
// -----------------------------------------------------------------------------
module cache_way_bank
    import cache_way_array_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int TAG_W  = 21,
    parameter int LINE_W = 128
) (
    input  logic                      clk,
    input  logic                      clr_en_i,
    input  logic [$clog2(SETS)-1:0]   clr_idx_i,
    input  logic                      wr_en_i,
    input  req_op_e                   op_i,
    input  logic [$clog2(SETS)-1:0]   idx_i,
    input  logic [TAG_W-1:0]          tag_i,
    input  logic [LINE_W-1:0]         wdata_i,
    input  logic [LINE_W/8-1:0]       wstrb_i,
    input  logic                      dirty_i,
    output logic [TAG_W-1:0]          rd_tag_o,
    output tag_meta_t                 rd_meta_o,
    output logic [LINE_W-1:0]         rd_data_o
);
    localparam int STRB_W = LINE_W / 8;

    logic [STRB_W-1:0][7:0] data_q [SETS];
    logic [TAG_W-1:0]       tag_q  [SETS];
    tag_meta_t              meta_q [SETS];
    logic [STRB_W-1:0][7:0] wbytes;

    assign wbytes = wdata_i;

    // Data and tags are never reset.
    always_ff @(posedge clk) begin
        if (wr_en_i && op_i == OP_FILL) begin
            data_q[idx_i] <= wbytes;
            tag_q[idx_i]  <= tag_i;
        end else if (wr_en_i && op_i == OP_WRITE) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) data_q[idx_i][b] <= wbytes[b];
            end
        end
    end

    // Flags: only the sweep clears them; ops never overlap a sweep.
    always_ff @(posedge clk) begin
        if (clr_en_i) begin
            meta_q[clr_idx_i] <= '0;
        end else if (wr_en_i) begin
            case (op_i)
                OP_FILL: begin
                    meta_q[idx_i].valid  <= 1'b1;
                    meta_q[idx_i].dirty  <= dirty_i;
`ifdef CACHE_ARRAY_PARITY_EN
                    meta_q[idx_i].parity <= ^{tag_i, dirty_i};
`endif
                end
                OP_WRITE: begin
                    if (dirty_i) begin
                        meta_q[idx_i].dirty  <= 1'b1;
`ifdef CACHE_ARRAY_PARITY_EN
                        meta_q[idx_i].parity <= ^{tag_q[idx_i], 1'b1};
`endif
                    end
                end
                OP_INVAL: begin
                    meta_q[idx_i].valid  <= 1'b0;
                    meta_q[idx_i].dirty  <= 1'b0;
`ifdef CACHE_ARRAY_PARITY_EN
                    meta_q[idx_i].parity <= ^{tag_q[idx_i], 1'b0};
`endif
                end
                default: ;
            endcase
        end
    end

    assign rd_tag_o  = tag_q[idx_i];
    assign rd_meta_o = meta_q[idx_i];
    assign rd_data_o = data_q[idx_i];

endmodule

// File: rtl/cache_way_array.sv
// -----------------------------------------------------------------------------
// cache_way_array
// N-way set-associative cache storage with 1-cycle-latency lookup, tag
// compare, hit-way select, victim reporting and a round-robin victim pointer
// per set. Valid/dirty/pointer state is cleared by a sweep FSM (after reset
// and on flush_req), one set per cycle.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready, req_op, req_index, req_tag, req_way, req_wdata,
//   req_wstrb, req_dirty          request channel
//   flush_req/flush_done          start sweep / end-of-sweep pulse
//   resp_valid, resp_hit, resp_way, resp_rdata, resp_victim_tag,
//   resp_victim_dirty             lookup response (held when resp_valid=0)
//   resp_perr                     parity error (CACHE_ARRAY_PARITY_EN only)
// Optional feature macro: CACHE_ARRAY_PARITY_EN.
// -----------------------------------------------------------------------------
module cache_way_array
    import cache_way_array_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int TAG_W  = 21,
    parameter int LINE_W = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [$clog2(SETS)-1:0]  req_index,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic [$clog2(WAYS)-1:0]  req_way,
    input  logic [LINE_W-1:0]        req_wdata,
    input  logic [LINE_W/8-1:0]      req_wstrb,
    input  logic                     req_dirty,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [$clog2(WAYS)-1:0]  resp_way,
    output logic [LINE_W-1:0]        resp_rdata,
    output logic [TAG_W-1:0]         resp_victim_tag,
    output logic                     resp_victim_dirty
`ifdef CACHE_ARRAY_PARITY_EN
    ,
    output logic                     resp_perr
`endif
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = $clog2(SETS);

    sweep_state_e       state_q;
    logic [IDX_W-1:0]   ctr_q;
    logic               flush_done_q;
    logic [WAY_W-1:0]   vptr_q [SETS];

    req_op_e op;
    logic    sweeping, fire, lookup_fire;

    assign op          = req_op_e'(req_op);
    assign sweeping    = (state_q == ST_SWEEP);
    assign req_ready   = (state_q == ST_IDLE) && !flush_req;
    assign fire        = req_valid && req_ready;
    assign lookup_fire = fire && (op == OP_LOOKUP);
    assign flush_done  = flush_done_q;

    // ---------------- way banks ----------------
    logic      [WAYS-1:0][TAG_W-1:0]  rd_tag;
    tag_meta_t [WAYS-1:0]             rd_meta;
    logic      [WAYS-1:0][LINE_W-1:0] rd_data;
    logic      [WAYS-1:0]             valid, match;
`ifdef CACHE_ARRAY_PARITY_EN
    logic      [WAYS-1:0]             bad;
`endif

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_bank #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_bank (
            .clk       (clk),
            .clr_en_i  (sweeping),
            .clr_idx_i (ctr_q),
            .wr_en_i   (fire && (op != OP_LOOKUP) && (req_way == WAY_W'(w))),
            .op_i      (op),
            .idx_i     (req_index),
            .tag_i     (req_tag),
            .wdata_i   (req_wdata),
            .wstrb_i   (req_wstrb),
            .dirty_i   (req_dirty),
            .rd_tag_o  (rd_tag[w]),
            .rd_meta_o (rd_meta[w]),
            .rd_data_o (rd_data[w])
        );
        assign valid[w] = rd_meta[w].valid;
`ifdef CACHE_ARRAY_PARITY_EN
        // Stored parity makes {tag, dirty, parity} even; a corrupted way never hits.
        assign bad[w]   = valid[w] && (^{rd_tag[w], rd_meta[w].dirty, rd_meta[w].parity});
        assign match[w] = valid[w] && (rd_tag[w] == req_tag) && !bad[w];
`else
        assign match[w] = valid[w] && (rd_tag[w] == req_tag);
`endif
    end

    // ---------------- compare / victim select ----------------
    logic             hit;
    logic [WAY_W-1:0] hit_way, victim_way, sel_way;

    // Descending scan so the lowest-numbered candidate wins.
    always_comb begin
        hit_way    = '0;
        victim_way = vptr_q[req_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) hit_way    = WAY_W'(w);
            if (!valid[w]) victim_way = WAY_W'(w);
        end
    end

    assign hit     = |match;
    assign sel_way = hit ? hit_way : victim_way;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SWEEP;
            ctr_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                ST_SWEEP: begin
                    ctr_q <= ctr_q + IDX_W'(1);
                    if (ctr_q == IDX_W'(SETS - 1)) begin
                        state_q      <= ST_IDLE;
                        flush_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (flush_req) begin
                        ctr_q   <= '0;
                        state_q <= ST_SWEEP;
                    end
                end
                default: state_q <= ST_SWEEP;
            endcase
        end
    end

    // Round-robin pointer: next victim is the way after the last fill.
    always_ff @(posedge clk) begin
        if (sweeping)
            vptr_q[ctr_q] <= '0;
        else if (fire && op == OP_FILL)
            vptr_q[req_index] <= req_way + WAY_W'(1);
    end

    // ---------------- response registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid        <= 1'b0;
            resp_hit          <= 1'b0;
            resp_way          <= '0;
            resp_rdata        <= '0;
            resp_victim_tag   <= '0;
            resp_victim_dirty <= 1'b0;
`ifdef CACHE_ARRAY_PARITY_EN
            resp_perr         <= 1'b0;
`endif
        end else begin
            resp_valid <= lookup_fire;
            if (lookup_fire) begin
                resp_hit          <= hit;
                resp_way          <= sel_way;
                resp_rdata        <= rd_data[sel_way];
                resp_victim_tag   <= rd_tag[victim_way];
                resp_victim_dirty <= rd_meta[victim_way].valid && rd_meta[victim_way].dirty;
`ifdef CACHE_ARRAY_PARITY_EN
                resp_perr         <= |bad;
`endif
            end
        end
    end

endmodule
